// File: rtl/temp_room_model.sv
// temp_room_model: thermal plant for closing the temperature-controller loop.
// Heat/cool commands move the room temperature one degree per HEAT_DIV /
// COOL_DIV cycles; with no command the room drifts toward ambient once per
// DRIFT_DIV cycles. Both commands at once freeze the room and raise fault.
//
// Handshake: there is none. h_i/c_i are level commands sampled on every
// rising edge; load_i is a single-cycle strobe sampled on the same edge.
//
// Step timing: the counter reaching DIV-1 arms a pending step, which is
// applied on the following edge. A mode entered at edge E0 therefore
// produces its first step at E0+DIV+1 and then one step every DIV edges.
// A pending step is discarded if the mode changes, load fires, or reset hits.
module temp_room_model #(
   parameter int WIDTH     = 7,
   parameter int HEAT_DIV  = 4,
   parameter int COOL_DIV  = 4,
   parameter int DRIFT_DIV = 16,
   parameter int TMAX      = 127,
   parameter int TMIN      = 0,
   parameter int INIT_TEMP = 20
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_temp_i,
   input  logic [WIDTH-1:0] tamb_i,
   input  logic             h_i,
   input  logic             c_i,
   output logic [WIDTH-1:0] troom_o,
   output logic             step_o,
   output logic             at_limit_o,
   output logic             fault_o,
   output logic [1:0]       state_o
);

   // Largest divider sets the counter width; the counter never exceeds DIV-1.
   localparam int MAXDIV_HC = (HEAT_DIV > COOL_DIV) ? HEAT_DIV : COOL_DIV;
   localparam int MAXDIV    = (MAXDIV_HC > DRIFT_DIV) ? MAXDIV_HC : DRIFT_DIV;
   localparam int CW        = (MAXDIV > 2) ? $clog2(MAXDIV) : 1;

   localparam logic [CW-1:0]    HEAT_LAST  = CW'(HEAT_DIV - 1);
   localparam logic [CW-1:0]    COOL_LAST  = CW'(COOL_DIV - 1);
   localparam logic [CW-1:0]    DRIFT_LAST = CW'(DRIFT_DIV - 1);
   localparam logic [WIDTH-1:0] TMAX_W     = WIDTH'(TMAX);
   localparam logic [WIDTH-1:0] TMIN_W     = WIDTH'(TMIN);
   localparam logic [WIDTH-1:0] INIT_W     = WIDTH'(INIT_TEMP);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HEAT  = 2'd1,
      S_COOL  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t           state_q, state_d, req_mode;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_last;
   logic             pend_q, pend_d;
   logic [WIDTH-1:0] troom_q, troom_d, load_clamped;
   logic             step_q, step_d;
   logic             at_limit_q, at_limit_d;
   logic             fault_q, fault_d;
   logic             below_max, above_min;

   // Out-of-range load values are forced into [TMIN, TMAX].
   function automatic logic [WIDTH-1:0] clamp_temp(input logic [WIDTH-1:0] v);
      int vi;
      vi = int'({1'b0, v});
      if (vi > TMAX) begin
         return TMAX_W;
      end else if (vi < TMIN) begin
         return TMIN_W;
      end else begin
         return v;
      end
   endfunction

   // Requested mode decoded from the controller commands.
   always_comb begin
      req_mode = S_IDLE;
      if (h_i && c_i) begin
         req_mode = S_FAULT;
      end else if (h_i) begin
         req_mode = S_HEAT;
      end else if (c_i) begin
         req_mode = S_COOL;
      end
   end

   // Terminal count and saturation flags for the current mode and temperature.
   always_comb begin
      cnt_last     = DRIFT_LAST;
      case (state_q)
         S_HEAT:  cnt_last = HEAT_LAST;
         S_COOL:  cnt_last = COOL_LAST;
         default: cnt_last = DRIFT_LAST;
      endcase
      below_max    = int'({1'b0, troom_q}) < TMAX;
      above_min    = int'({1'b0, troom_q}) > TMIN;
      load_clamped = clamp_temp(load_temp_i);
   end

   // Next-state logic: load first, then mode change, then fault freeze,
   // then the ordinary count / pending-step path.
   always_comb begin
      state_d = req_mode;
      cnt_d   = cnt_q;
      pend_d  = 1'b0;
      troom_d = troom_q;
      step_d  = 1'b0;

      if (load_i) begin
         troom_d = load_clamped;
         cnt_d   = '0;
      end else if (req_mode != state_q) begin
         cnt_d = '0;
      end else if (state_q == S_FAULT) begin
         cnt_d = '0;
      end else begin
         // Apply a step armed on the previous edge.
         if (pend_q) begin
            case (state_q)
               S_HEAT: begin
                  if (below_max) begin
                     troom_d = troom_q + 1'b1;
                     step_d  = 1'b1;
                  end
               end
               S_COOL: begin
                  if (above_min) begin
                     troom_d = troom_q - 1'b1;
                     step_d  = 1'b1;
                  end
               end
               default: begin
                  if (troom_q < tamb_i) begin
                     troom_d = troom_q + 1'b1;
                     step_d  = 1'b1;
                  end else if (troom_q > tamb_i) begin
                     troom_d = troom_q - 1'b1;
                     step_d  = 1'b1;
                  end
               end
            endcase
         end
         // Idle at ambient parks the counter; otherwise count toward DIV-1.
         if ((state_q == S_IDLE) && (troom_q == tamb_i)) begin
            cnt_d = '0;
         end else if (cnt_q == cnt_last) begin
            cnt_d  = '0;
            pend_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      fault_d    = (state_d == S_FAULT);
      at_limit_d = ((state_d == S_HEAT) && (troom_d == TMAX_W)) ||
                   ((state_d == S_COOL) && (troom_d == TMIN_W));
   end

   // State, counter and registered outputs; reset restores the power-up room.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         troom_q    <= INIT_W;
         step_q     <= 1'b0;
         at_limit_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         troom_q    <= troom_d;
         step_q     <= step_d;
         at_limit_q <= at_limit_d;
         fault_q    <= fault_d;
      end
   end

   assign troom_o    = troom_q;
   assign step_o     = step_q;
   assign at_limit_o = at_limit_q;
   assign fault_o    = fault_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_temp_room_model.sv
// Bench for temp_room_model: directed scenarios followed by randomized
// command sequences, all checked every cycle against an age-based model.
module tb_temp_room_model;
   localparam int W    = 7;
   localparam int HD   = 4;
   localparam int CD   = 4;
   localparam int DD   = 16;
   localparam int TMAX = 127;
   localparam int TMIN = 0;
   localparam int INIT = 20;
   localparam int M_IDLE = 0, M_HEAT = 1, M_COOL = 2, M_FAULT = 3;

   logic         clk = 1'b0;
   logic         reset, load, h, c;
   logic [W-1:0] load_temp, tamb;
   logic [W-1:0] troom;
   logic         step, at_limit, fault;
   logic [1:0]   state;

   int checks = 0;
   int errors = 0;

   // Reference model: mode plus "age" = edges spent in the current run.
   int m_troom, m_mode, m_age;
   int m_step, m_fault, m_atl;

   always #5 clk = ~clk;

   temp_room_model #(
      .WIDTH(W), .HEAT_DIV(HD), .COOL_DIV(CD), .DRIFT_DIV(DD),
      .TMAX(TMAX), .TMIN(TMIN), .INIT_TEMP(INIT)
   ) dut (
      .clk_i(clk), .reset_i(reset), .load_i(load), .load_temp_i(load_temp),
      .tamb_i(tamb), .h_i(h), .c_i(c), .troom_o(troom), .step_o(step),
      .at_limit_o(at_limit), .fault_o(fault), .state_o(state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // A run entered at age 0 steps at ages DIV+1, 2*DIV+1, ...
   task automatic model_edge();
      int req, div, lt;
      m_step = 0;
      if (reset) begin
         m_troom = INIT; m_mode = M_IDLE; m_age = 0;
         m_fault = 0; m_atl = 0;
         return;
      end
      req = (h && c) ? M_FAULT : h ? M_HEAT : c ? M_COOL : M_IDLE;
      if (load) begin
         lt = int'(load_temp);
         if (lt > TMAX) lt = TMAX;
         if (lt < TMIN) lt = TMIN;
         m_troom = lt;
         m_age = 0;
      end else if (req != m_mode || req == M_FAULT) begin
         m_age = 0;
      end else if (req == M_IDLE && m_troom == int'(tamb)) begin
         m_age = 0;
      end else begin
         m_age++;
         div = (req == M_HEAT) ? HD : (req == M_COOL) ? CD : DD;
         if (m_age > div && (m_age - 1) % div == 0) begin
            if (req == M_HEAT && m_troom < TMAX) begin
               m_troom++; m_step = 1;
            end else if (req == M_COOL && m_troom > TMIN) begin
               m_troom--; m_step = 1;
            end else if (req == M_IDLE && m_troom != int'(tamb)) begin
               m_troom += (m_troom < int'(tamb)) ? 1 : -1;
               m_step = 1;
            end
         end
      end
      m_mode  = req;
      m_fault = (req == M_FAULT) ? 1 : 0;
      m_atl   = ((req == M_HEAT && m_troom == TMAX) ||
                 (req == M_COOL && m_troom == TMIN)) ? 1 : 0;
   endtask

   // Drive one cycle, advance the model on the edge, compare 1 ns later.
   task automatic tick(input bit r, input bit ld, input int lt, input bit hh, input bit cc);
      reset = r; load = ld; load_temp = W'(lt); h = hh; c = cc;
      @(posedge clk);
      model_edge();
      #1;
      chk("troom", 32'(troom), 32'(m_troom));
      chk("step", 32'(step), 32'(m_step));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("at_limit", 32'(at_limit), 32'(m_atl));
      chk("state", 32'(state), 32'(m_mode));
   endtask

   task automatic run(input int n, input bit hh, input bit cc);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, hh, cc);
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; load_temp = '0; h = 1'b0; c = 1'b0;
      tamb = W'(20);
      m_troom = INIT; m_mode = M_IDLE; m_age = 0;
      m_step = 0; m_fault = 0; m_atl = 0;

      // Reset state.
      tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
      chk("reset_troom", 32'(troom), 32'd20);
      chk("reset_flags", 32'({step, at_limit, fault}), 32'd0);

      // Heating from 20: first step 5 edges after h is first sampled.
      run(5, 1'b1, 1'b0);
      chk("heat_before_first", 32'(troom), 32'd20);
      run(1, 1'b1, 1'b0);
      chk("heat_first", 32'(troom), 32'd21);
      chk("heat_first_step", 32'(step), 32'd1);
      run(4, 1'b1, 1'b0);
      chk("heat_second", 32'(troom), 32'd22);
      run(4, 1'b1, 1'b0);
      chk("heat_third", 32'(troom), 32'd23);

      // Upper saturation.
      tick(1'b0, 1'b1, 126, 1'b1, 1'b0);
      run(5, 1'b1, 1'b0);
      chk("tmax_reach", 32'(troom), 32'd127);
      chk("tmax_at_limit", 32'(at_limit), 32'd1);
      run(10, 1'b1, 1'b0);
      chk("tmax_hold", 32'(troom), 32'd127);

      // Lower saturation.
      tick(1'b0, 1'b1, 1, 1'b0, 1'b1);
      run(5, 1'b0, 1'b1);
      chk("tmin_reach", 32'(troom), 32'd0);
      chk("tmin_at_limit", 32'(at_limit), 32'd1);
      run(10, 1'b0, 1'b1);

      // Heat then switch to cool: counter restarts on the switch.
      tamb = W'(20);
      tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
      run(3, 1'b1, 1'b0);
      run(5, 1'b0, 1'b1);
      chk("switch_no_step", 32'(troom), 32'd20);
      run(1, 1'b0, 1'b1);
      chk("switch_first_cool", 32'(troom), 32'd19);

      // Idle drift toward ambient 22.
      tamb = W'(22);
      tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
      run(17, 1'b0, 1'b0);
      chk("drift_first", 32'(troom), 32'd21);
      run(16, 1'b0, 1'b0);
      chk("drift_second", 32'(troom), 32'd22);
      run(40, 1'b0, 1'b0);
      chk("drift_parked", 32'(troom), 32'd22);

      // Fault interval mid-heat.
      tamb = W'(20);
      tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
      run(8, 1'b1, 1'b0);
      run(10, 1'b1, 1'b1);
      chk("fault_frozen", 32'(troom), 32'd21);
      chk("fault_flag", 32'(fault), 32'd1);
      run(1, 1'b1, 1'b0);
      chk("fault_clears", 32'(fault), 32'd0);
      run(4, 1'b1, 1'b0);
      chk("fault_resume_wait", 32'(troom), 32'd21);
      run(1, 1'b1, 1'b0);
      chk("fault_resume_step", 32'(troom), 32'd22);

      // Reset mid-count, then reset beating load.
      tick(1'b0, 1'b1, 35, 1'b1, 1'b0);
      run(2, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 0, 1'b1, 1'b0);
      chk("midreset_troom", 32'(troom), 32'd20);
      chk("midreset_flags", 32'({step, at_limit, fault}), 32'd0);
      tick(1'b1, 1'b1, 90, 1'b0, 1'b0);
      chk("reset_beats_load", 32'(troom), 32'd20);

      // Randomized command segments with occasional load, reset and ambient moves.
      for (int seg = 0; seg < 120; seg++) begin
         int len, mode;
         len  = $urandom_range(1, 30);
         mode = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) tamb = W'($urandom_range(0, 127));
         for (int i = 0; i < len; i++) begin
            int r;
            r = $urandom_range(0, 99);
            tick(r == 0, r >= 96, int'($urandom_range(0, 127)), mode[0], mode[1]);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
